mc10_exp_cart: RTL and testbench

- Expansion-port peripheral: the device end of the MC-10 expansion bus.
- Consumes the host's exp_out bundle (R/W, A15-A0, E) and drives the host's exp_in bundle (D7-D0, nmi, reset, sel).
- Implements a bank-switched ROM cartridge, loaded through the MiSTer download port, plus reset/NMI pulse generation for the host CPU.
- Sits beside the mc10 top; its exp_in output wires straight to the host's exp_in.

---
 rtl/mc10_exp_cart.sv | 226 ++++++++++++++++++++++
 tb/tb_mc10_exp_cart.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc10_exp_cart.sv
// MC-10 expansion-port cartridge: bank-switched download ROM plus host reset/NMI pulse generation.
// Define MC10_EXP_CART_RAM_EN to add the 2 KB shadow RAM above the ROM window (and the ram_we port).
module mc10_exp_cart #(
   parameter logic [15:0] WIN_BASE  = 16'h5000,
   parameter int          WIN_BITS  = 14,
   parameter int          BANK_BITS = 2,
   parameter logic [15:0] BANK_ADDR = 16'hBFFC,
   parameter logic [15:0] RST_PULSE = 16'd4096,
   parameter logic [15:0] NMI_PULSE = 16'd64
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        enable,
   input  logic [17:0] exp_out,
   output logic [10:0] exp_in,
   input  logic        dl_active,
   input  logic        dl_wr,
   input  logic [15:0] dl_addr,
   input  logic [7:0]  dl_data,
   input  logic        btn_reset,
`ifdef MC10_EXP_CART_RAM_EN
   input  logic        ram_we,
`endif
   input  logic        btn_nmi
);
   // Pulse FSMs (reset and NMI share the encoding):
   //   state   | meaning
   //   P_IDLE  | no pulse, output low
   //   P_PULSE | pulse running, counter holds remaining cycles

   typedef enum logic {P_IDLE, P_PULSE} pulse_t;

   localparam int ROM_AW = WIN_BITS + BANK_BITS;

   logic        bus_rw;
   logic [15:0] bus_a;
   assign bus_rw = exp_out[17];
   assign bus_a  = exp_out[16:1];

   logic [1:0] e_sync, rb_sync, nb_sync;
   logic       e_d, rb_d, nb_d, dl_d, alive;
   logic       e_s, rb_s, nb_s, e_fall;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         e_sync  <= '0;
         rb_sync <= '0;
         nb_sync <= '0;
         e_d     <= 1'b0;
         rb_d    <= 1'b0;
         nb_d    <= 1'b0;
         dl_d    <= 1'b0;
         alive   <= 1'b0;
      end else begin
         e_sync  <= {e_sync[0], exp_out[0]};
         rb_sync <= {rb_sync[0], btn_reset};
         nb_sync <= {nb_sync[0], btn_nmi};
         e_d     <= e_s;
         rb_d    <= rb_s;
         nb_d    <= nb_s;
         dl_d    <= dl_active;
         alive   <= 1'b1;
      end
   end

   assign e_s    = e_sync[1];
   assign rb_s   = rb_sync[1];
   assign nb_s   = nb_sync[1];
   assign e_fall = ~e_s & e_d;

   // Window decode by offset so the window need not be aligned to its own size.
   logic [15:0] win_off;
   logic        win_hit, bank_hit, ram_hit;
   logic [7:0]  ram_rd;

   assign win_off  = bus_a - WIN_BASE;
   assign win_hit  = enable & (win_off[15:WIN_BITS] == '0);
   assign bank_hit = enable & (bus_a[15:BANK_BITS] == BANK_ADDR[15:BANK_BITS]);

   logic [BANK_BITS-1:0] bank;
   logic [7:0]           rom [0:(1<<ROM_AW)-1];
   logic [7:0]           rd_q;
   logic [ROM_AW-1:0]    rom_addr;

   assign rom_addr = {bank, win_off[WIN_BITS-1:0]};

   always_ff @(posedge clk_sys) begin
      if (dl_wr)
         rom[dl_addr[ROM_AW-1:0]] <= dl_data;
      rd_q <= rom[rom_addr];
   end

`ifdef MC10_EXP_CART_RAM_EN
   localparam logic [15:0] RAM_BASE = WIN_BASE + 16'(1 << WIN_BITS);

   logic [15:0] ram_off;
   logic [7:0]  ram [0:2047];

   assign ram_off = bus_a - RAM_BASE;
   assign ram_hit = enable & (ram_off[15:11] == '0);

   // No data lines on the bus: a write stores the low byte of the address-derived pattern.
   always_ff @(posedge clk_sys) begin
      if (e_fall & ~bus_rw & ram_we & ram_hit)
         ram[ram_off[10:0]] <= bus_a[7:0];
      ram_rd <= ram[ram_off[10:0]];
   end
`else
   assign ram_hit = 1'b0;
   assign ram_rd  = 8'h00;
`endif

   // Reset pulse FSM
   pulse_t      rst_state, rst_state_nxt;
   logic [15:0] rst_cnt, rst_cnt_nxt;
   logic        rst_trig, rst_q, rst_q_nxt;

   assign rst_trig = ~alive | (dl_d & ~dl_active) | (rb_s & ~rb_d);

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         rst_state <= P_IDLE;
         rst_cnt   <= RST_PULSE;
         rst_q     <= 1'b0;
      end else begin
         rst_state <= rst_state_nxt;
         rst_cnt   <= rst_cnt_nxt;
         rst_q     <= rst_q_nxt;
      end
   end

   always_comb begin
      rst_state_nxt = rst_state;
      rst_cnt_nxt   = rst_cnt;
      if (rst_trig) begin
         rst_state_nxt = P_PULSE;
         rst_cnt_nxt   = RST_PULSE;
      end else if (rst_state == P_PULSE) begin
         rst_cnt_nxt = rst_cnt - 16'd1;
         if (rst_cnt <= 16'd1) begin
            rst_state_nxt = P_IDLE;
            rst_cnt_nxt   = 16'd0;
         end
      end
   end

   always_comb begin
      rst_q_nxt = (rst_state_nxt == P_PULSE) | dl_active;
   end

   // NMI pulse FSM; held idle whenever the reset pulse owns the host.
   pulse_t      nmi_state, nmi_state_nxt;
   logic [15:0] nmi_cnt, nmi_cnt_nxt;
   logic        nmi_q, nmi_q_nxt, rst_busy;

   assign rst_busy = (rst_state_nxt == P_PULSE) | dl_active;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         nmi_state <= P_IDLE;
         nmi_cnt   <= 16'd0;
         nmi_q     <= 1'b0;
      end else begin
         nmi_state <= nmi_state_nxt;
         nmi_cnt   <= nmi_cnt_nxt;
         nmi_q     <= nmi_q_nxt;
      end
   end

   always_comb begin
      nmi_state_nxt = nmi_state;
      nmi_cnt_nxt   = nmi_cnt;
      if (rst_busy) begin
         nmi_state_nxt = P_IDLE;
         nmi_cnt_nxt   = 16'd0;
      end else begin
         case (nmi_state)
            P_IDLE: begin
               if (nb_s & ~nb_d) begin
                  nmi_state_nxt = P_PULSE;
                  nmi_cnt_nxt   = NMI_PULSE;
               end
            end
            P_PULSE: begin
               nmi_cnt_nxt = nmi_cnt - 16'd1;
               if (nmi_cnt <= 16'd1) begin
                  nmi_state_nxt = P_IDLE;
                  nmi_cnt_nxt   = 16'd0;
               end
            end
            default: nmi_state_nxt = P_IDLE;
         endcase
      end
   end

   always_comb begin
      nmi_q_nxt = (nmi_state_nxt == P_PULSE);
   end

   // A reset trigger or an active download clears the bank ahead of any latch write.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)
         bank <= '0;
      else if (rst_trig | dl_active)
         bank <= '0;
      else if (e_fall & ~bus_rw & bank_hit)
         bank <= bus_a[BANK_BITS-1:0];
   end

   logic       rd_en, sel;
   logic [7:0] data;

   assign rd_en = alive & e_s & bus_rw;
   assign sel   = alive & (win_hit | bank_hit | ram_hit);

   always_comb begin
      data = 8'h00;
      if (rd_en & win_hit)
         data = rd_q;
      else if (rd_en & ram_hit)
         data = ram_rd;
   end

   assign exp_in = {data, nmi_q, rst_q, sel};

endmodule

// File: tb/tb_mc10_exp_cart.sv
// Directed self-checking bench for mc10_exp_cart: reset/NMI pulses, download, banking, decode.
module tb_mc10_exp_cart;
   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        enable;
   logic [17:0] exp_out;
   logic [10:0] exp_in;
   logic        dl_active;
   logic        dl_wr;
   logic [15:0] dl_addr;
   logic [7:0]  dl_data;
   logic        btn_reset;
   logic        btn_nmi;

   int n_checks = 0;
   int n_fail   = 0;

   mc10_exp_cart dut (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .enable    (enable),
      .exp_out   (exp_out),
      .exp_in    (exp_in),
      .dl_active (dl_active),
      .dl_wr     (dl_wr),
      .dl_addr   (dl_addr),
      .dl_data   (dl_data),
      .btn_reset (btn_reset),
      .btn_nmi   (btn_nmi)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic bus_read(input logic [15:0] a, output logic [7:0] d, output logic s);
      @(negedge clk_sys);
      exp_out = {1'b1, a, 1'b0};
      repeat (2) @(negedge clk_sys);
      exp_out[0] = 1'b1;
      repeat (4) @(negedge clk_sys);
      d = exp_in[10:3];
      s = exp_in[0];
      exp_out[0] = 1'b0;
      repeat (4) @(negedge clk_sys);
      exp_out = '0;
   endtask

   task automatic bus_write(input logic [15:0] a);
      @(negedge clk_sys);
      exp_out = {1'b0, a, 1'b0};
      repeat (2) @(negedge clk_sys);
      exp_out[0] = 1'b1;
      repeat (4) @(negedge clk_sys);
      exp_out[0] = 1'b0;
      repeat (6) @(negedge clk_sys);
      exp_out = '0;
   endtask

   task automatic dl_byte(input logic [15:0] a, input logic [7:0] d);
      @(negedge clk_sys);
      dl_addr = a;
      dl_data = d;
      dl_wr   = 1'b1;
      @(negedge clk_sys);
      dl_wr   = 1'b0;
   endtask

   // Counts high samples of the host reset line until it drops; bounded.
   task automatic measure_rst(output int n);
      n = 0;
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk_sys);
         if (exp_in[1]) n++;
         else if (n > 0) break;
      end
   endtask

   task automatic test_reset;
      int n;
      reset_n = 1'b0;
      exp_out = {1'b1, 16'h5000, 1'b1};
      repeat (3) @(negedge clk_sys);
      n_checks++;
      if (exp_in !== 11'h000) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h expected %h", exp_in, 11'h000);
      end
      exp_out = '0;
      @(negedge clk_sys);
      reset_n = 1'b1;
      measure_rst(n);
      n_checks++;
      if (n !== 4096) begin
         n_fail++;
         $display("FAIL reset_pulse_len: got %0d expected %0d", n, 4096);
      end
      n_checks++;
      if (exp_in !== 11'h000) begin
         n_fail++;
         $display("FAIL idle_outputs: got %h expected %h", exp_in, 11'h000);
      end
   endtask

   task automatic test_download;
      logic [7:0] d;
      logic       s;
      int         n;
      @(negedge clk_sys);
      dl_active = 1'b1;
      repeat (3) @(negedge clk_sys);
      n_checks++;
      if (exp_in[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL dl_holds_reset: got %b expected %b", exp_in[1], 1'b1);
      end
      dl_byte(16'h0000, 8'hA5);
      dl_byte(16'h4000, 8'h3C);
      dl_byte(16'h3FFF, 8'h77);
      bus_read(16'h5000, d, s);
      n_checks++;
      if (d !== 8'hA5 || s !== 1'b1) begin
         n_fail++;
         $display("FAIL read_5000_dl: got data %h sel %b expected data %h sel %b", d, s, 8'hA5, 1'b1);
      end
      @(negedge clk_sys);
      dl_active = 1'b0;
      measure_rst(n);
      n_checks++;
      if (n !== 4096) begin
         n_fail++;
         $display("FAIL dl_fall_pulse_len: got %0d expected %0d", n, 4096);
      end
   endtask

   task automatic test_bank;
      logic [7:0] d;
      logic       s;
      int         n;
      bus_write(16'hBFFD);
      bus_read(16'h5000, d, s);
      n_checks++;
      if (d !== 8'h3C || s !== 1'b1) begin
         n_fail++;
         $display("FAIL bank1_read: got data %h sel %b expected data %h sel %b", d, s, 8'h3C, 1'b1);
      end
      @(negedge clk_sys);
      btn_reset = 1'b1;
      measure_rst(n);
      btn_reset = 1'b0;
      n_checks++;
      if (n !== 4096) begin
         n_fail++;
         $display("FAIL btn_reset_pulse_len: got %0d expected %0d", n, 4096);
      end
      bus_read(16'h5000, d, s);
      n_checks++;
      if (d !== 8'hA5) begin
         n_fail++;
         $display("FAIL bank_cleared_read: got %h expected %h", d, 8'hA5);
      end
      n_checks++;
      if (exp_in[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL btn_release_no_retrigger: got %b expected %b", exp_in[1], 1'b0);
      end
   endtask

   task automatic test_decode;
      logic [7:0] d;
      logic       s;
      bus_read(16'h4FFF, d, s);
      n_checks++;
      if (d !== 8'h00 || s !== 1'b0) begin
         n_fail++;
         $display("FAIL read_4fff: got data %h sel %b expected data %h sel %b", d, s, 8'h00, 1'b0);
      end
      bus_read(16'h9000, d, s);
      n_checks++;
      if (d !== 8'h00 || s !== 1'b0) begin
         n_fail++;
         $display("FAIL read_9000: got data %h sel %b expected data %h sel %b", d, s, 8'h00, 1'b0);
      end
      bus_read(16'h8FFF, d, s);
      n_checks++;
      if (d !== 8'h77 || s !== 1'b1) begin
         n_fail++;
         $display("FAIL read_8fff: got data %h sel %b expected data %h sel %b", d, s, 8'h77, 1'b1);
      end
      bus_read(16'hBFFE, d, s);
      n_checks++;
      if (d !== 8'h00 || s !== 1'b1) begin
         n_fail++;
         $display("FAIL read_bank_reg: got data %h sel %b expected data %h sel %b", d, s, 8'h00, 1'b1);
      end
      bus_write(16'h5000);
      bus_read(16'h5000, d, s);
      n_checks++;
      if (d !== 8'hA5) begin
         n_fail++;
         $display("FAIL window_write_ignored: got %h expected %h", d, 8'hA5);
      end
      enable = 1'b0;
      bus_read(16'h5000, d, s);
      n_checks++;
      if (d !== 8'h00 || s !== 1'b0) begin
         n_fail++;
         $display("FAIL disabled_read: got data %h sel %b expected data %h sel %b", d, s, 8'h00, 1'b0);
      end
      enable = 1'b1;
   endtask

   task automatic test_nmi;
      int n;
      int r;
      @(negedge clk_sys);
      btn_nmi = 1'b1;
      n = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk_sys);
         if (exp_in[2]) n++;
         if (i == 20) btn_nmi = 1'b0;
         if (i == 26) btn_nmi = 1'b1;
      end
      btn_nmi = 1'b0;
      n_checks++;
      if (n !== 64) begin
         n_fail++;
         $display("FAIL nmi_pulse_len: got %0d expected %0d", n, 64);
      end
      repeat (5) @(negedge clk_sys);
      btn_reset = 1'b1;
      repeat (10) @(negedge clk_sys);
      btn_nmi = 1'b1;
      n = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk_sys);
         if (exp_in[2]) n++;
      end
      btn_reset = 1'b0;
      btn_nmi   = 1'b0;
      measure_rst(r);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_sys);
         if (exp_in[2]) n++;
      end
      n_checks++;
      if (n !== 0) begin
         n_fail++;
         $display("FAIL nmi_suppressed: got %0d high cycles expected %0d", n, 0);
      end
   endtask

   task automatic test_async_reset;
      logic [7:0] d;
      logic       s;
      int         n;
      bus_write(16'hBFFD);
      @(negedge clk_sys);
      exp_out = {1'b1, 16'h5000, 1'b0};
      repeat (2) @(negedge clk_sys);
      exp_out[0] = 1'b1;
      repeat (4) @(negedge clk_sys);
      n_checks++;
      if (exp_in[10:3] !== 8'h3C) begin
         n_fail++;
         $display("FAIL pre_reset_read: got %h expected %h", exp_in[10:3], 8'h3C);
      end
      #2 reset_n = 1'b0;
      #1;
      n_checks++;
      if (exp_in !== 11'h000) begin
         n_fail++;
         $display("FAIL async_reset_outputs: got %h expected %h", exp_in, 11'h000);
      end
      @(negedge clk_sys);
      exp_out = '0;
      repeat (2) @(negedge clk_sys);
      reset_n = 1'b1;
      measure_rst(n);
      n_checks++;
      if (n !== 4096) begin
         n_fail++;
         $display("FAIL post_reset_pulse_len: got %0d expected %0d", n, 4096);
      end
      bus_read(16'h5000, d, s);
      n_checks++;
      if (d !== 8'hA5) begin
         n_fail++;
         $display("FAIL post_reset_bank0: got %h expected %h", d, 8'hA5);
      end
   endtask

   initial begin
      reset_n   = 1'b0;
      enable    = 1'b1;
      exp_out   = '0;
      dl_active = 1'b0;
      dl_wr     = 1'b0;
      dl_addr   = '0;
      dl_data   = '0;
      btn_reset = 1'b0;
      btn_nmi   = 1'b0;
      test_reset;
      test_download;
      test_bank;
      test_decode;
      test_nmi;
      test_async_reset;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
